preg_ready_table: RTL
=====================

PREG_READY_TABLE -- requirements
Module: preg_ready_table

Interface
REQ-001 SHALL have parameter PREG_SIZE, default 64, number of physical registers.
REQ-002 SHALL have parameter NUM_READ, default 4, number of busy lookup ports.
REQ-003 SHALL have parameter NUM_ALLOC, default 2, number of rename allocate ports.
REQ-004 SHALL have parameter NUM_WAKE, default 2, number of writeback wakeup ports.
REQ-005 SHALL have parameter NUM_WALK, default 2, number of ROB walk ports.
REQ-006 SHALL have parameter LAT_W, default 2, width of the wakeup latency field.
REQ-007 SHALL derive PREG_W = $clog2(PREG_SIZE).
REQ-008 SHALL have the following ports:
- clock  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- read_addr  in  NUM_READ*PREG_W  lookup addresses
- busy_out  out  NUM_READ  1 = operand not ready
- alloc_en / alloc_addr  in  NUM_ALLOC / NUM_ALLOC*PREG_W  mark busy
- wake_en / wake_addr / wake_lat  in  NUM_WAKE / NUM_WAKE*PREG_W / NUM_WAKE*LAT_W  scheduled ready
- rob_state  in  2  ROB_STATE_IDLE / OVERWRITE_RAT / WALKING
- walk_valid / walk_lrd / walk_prd  in  NUM_WALK / NUM_WALK*5 / NUM_WALK*PREG_W  squashed destinations

Function
REQ-009 SHALL hold one busy bit and one LAT_W-bit countdown per entry.
REQ-010 SHALL treat entry 0 as always ready: busy_out = 0 for addr 0; alloc, wake and walk to 0 are ignored.
REQ-011 alloc_en[i]: busy <= 1 and countdown <= 0 on the next edge.
REQ-012 wake_en[j] with wake_lat = 0: busy <= 0 on the next edge.
REQ-013 wake_en[j] with wake_lat = L > 0: countdown <= L; busy stays 1; reloads any pending countdown.
REQ-014 Nonzero countdown: decrements each cycle; at the edge where it goes from 1 to 0, busy <= 0. Ready is therefore visible L+1 cycles after the wake.
REQ-015 walk_valid[k] while rob_state = WALKING: busy <= 0 and countdown <= 0 for walk_prd; walk_lrd is unused apart from lint.
REQ-016 rob_state = OVERWRITE_RAT: every busy bit and countdown <= 0 on the next edge; all other inputs that cycle are ignored.
REQ-017 Same-entry priority within one cycle, highest first:
- overwrite
- walk
- lat-0 wake
- alloc
- latency-L wake load
- countdown expiry
Alloc cancels a countdown expiring in the same cycle, because that expiry belongs to the old producer.
REQ-018 Multiple wakes to one entry in one cycle: the lowest port index wins.
REQ-019 busy_out SHALL be combinational from the table plus the bypass of REQ-023; it has no output register.
REQ-020 Duplicate read addresses SHALL return identical values.

Reset
REQ-021 reset_n low: all busy bits = 0 and all countdowns = 0 immediately; busy_out = 0 for every address.
REQ-022 Reset deassertion mid-countdown: the countdown is lost and the entry stays ready; no pending expiry survives reset.

Configuration
REQ-023 Macro BUSYTABLE_BYPASS_EN defined: busy_out[r] = 0 when read_addr[r] matches a same-cycle lat-0 wake or an entry whose countdown equals 1. Undefined: busy_out reflects only registered state, giving one cycle more latency.

Structure
REQ-024 rob_state encodings, PREG_SIZE default and LAT_W default SHALL live in the shared backend package/defines.
REQ-025 One sub-module, preg_ready_entry, SHALL hold one entry (busy bit, countdown, priority logic) and be instantiated PREG_SIZE-1 times.

Verification (PREG_SIZE=64, BYPASS on unless stated)
REQ-026 Scenario 1: alloc p5 at cycle 0 -> busy_out for p5 = 1 at cycle 1; wake p5 lat 0 at cycle 3 -> 0 in cycle 3 (bypass) and 0 from cycle 4.
REQ-027 Scenario 2: alloc p9, then wake p9 lat 2 at cycle 2 -> busy in cycles 3-4, bypass 0 in cycle 4 with the macro defined, registered 0 from cycle 5; without the macro, 1 in cycle 4.
REQ-028 Scenario 3: pending lat-1 countdown on p12 plus alloc p12 in the same cycle -> p12 stays busy with no later spurious ready.
REQ-029 Scenario 4: alloc p20 and p21, then rob_state = WALKING with walk_prd {20,21} -> both ready next cycle; then OVERWRITE_RAT -> all 64 entries ready.
REQ-030 Scenario 5: alloc p0 and wake p0 -> busy_out for addr 0 is always 0; two wakes to p7 in one cycle with lats {0,3} -> port 0 wins and p7 is ready next cycle.
REQ-031 Scenario 6: assert reset_n low asynchronously during a lat-3 countdown on p30 -> busy_out = 0 immediately and no change after release.

Source files
------------

// File: rtl/preg_ready_table_pkg.sv
// Shared backend constants for the physical-register ready table:
// ROB state encodings and default table geometry.
package preg_ready_table_pkg;

  localparam logic [1:0] ROB_STATE_IDLE          = 2'd0;
  localparam logic [1:0] ROB_STATE_OVERWRITE_RAT = 2'd1;
  localparam logic [1:0] ROB_STATE_WALKING       = 2'd2;

  localparam int PREG_SIZE_DEFAULT = 64;
  localparam int LAT_W_DEFAULT     = 2;
  localparam int LREG_W            = 5;

  typedef logic [1:0] rob_state_t;

endpackage

// File: rtl/preg_ready_table_if.sv
// Lookup, allocate, wakeup and ROB-walk bundle for preg_ready_table.
// The master drives requests; the slave (the table) drives busy_out.
interface preg_ready_table_if
  import preg_ready_table_pkg::*;
#(
  parameter int PREG_SIZE = PREG_SIZE_DEFAULT,
  parameter int NUM_READ  = 4,
  parameter int NUM_ALLOC = 2,
  parameter int NUM_WAKE  = 2,
  parameter int NUM_WALK  = 2,
  parameter int LAT_W     = LAT_W_DEFAULT
);
  localparam int PREG_W = $clog2(PREG_SIZE);

  logic [NUM_READ*PREG_W-1:0]  read_addr;
  logic [NUM_READ-1:0]         busy_out;
  logic [NUM_ALLOC-1:0]        alloc_en;
  logic [NUM_ALLOC*PREG_W-1:0] alloc_addr;
  logic [NUM_WAKE-1:0]         wake_en;
  logic [NUM_WAKE*PREG_W-1:0]  wake_addr;
  logic [NUM_WAKE*LAT_W-1:0]   wake_lat;
  rob_state_t                  rob_state;
  logic [NUM_WALK-1:0]         walk_valid;
  logic [NUM_WALK*LREG_W-1:0]  walk_lrd;
  logic [NUM_WALK*PREG_W-1:0]  walk_prd;

  modport master (
    output read_addr, alloc_en, alloc_addr, wake_en, wake_addr, wake_lat,
           rob_state, walk_valid, walk_lrd, walk_prd,
    input  busy_out
  );

  modport slave (
    input  read_addr, alloc_en, alloc_addr, wake_en, wake_addr, wake_lat,
           rob_state, walk_valid, walk_lrd, walk_prd,
    output busy_out
  );

endinterface

// File: rtl/preg_ready_table_entry.sv
// One ready-table entry: busy bit, wakeup-latency countdown and the
// same-cycle priority between overwrite, walk, wake, alloc and expiry.
module preg_ready_entry
  import preg_ready_table_pkg::*;
#(
  parameter int LAT_W = LAT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             overwrite_i,
  input  logic             walk_i,
  input  logic             wakeNow_i,
  input  logic             alloc_i,
  input  logic             wakeLoad_i,
  input  logic [LAT_W-1:0] wakeLat_i,
  output logic             busy_o,
  output logic             expiring_o
);

  logic             busy_q, busy_d;
  logic [LAT_W-1:0] count_q, count_d;

  // An alloc or a reload in this cycle belongs to a new producer, so the
  // old countdown reaching 1 must not be advertised as an expiry.
  assign expiring_o = (count_q == LAT_W'(1)) && !alloc_i && !wakeLoad_i;
  assign busy_o     = busy_q;

  always_comb begin
    busy_d  = busy_q;
    count_d = count_q;
    if (overwrite_i || walk_i || wakeNow_i) begin
      busy_d  = 1'b0;
      count_d = '0;
    end else if (alloc_i) begin
      busy_d  = 1'b1;
      count_d = '0;
    end else if (wakeLoad_i) begin
      count_d = wakeLat_i;
    end else if (count_q != '0) begin
      count_d = count_q - LAT_W'(1);
      if (count_q == LAT_W'(1)) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q  <= 1'b0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/preg_ready_table.sv
// Physical-register ready (busy) table with multi-port lookup, alloc,
// latency wakeup and ROB recovery. Define BUSYTABLE_BYPASS_EN to bypass same-cycle readiness.
module preg_ready_table
  import preg_ready_table_pkg::*;
#(
  parameter int PREG_SIZE = PREG_SIZE_DEFAULT,
  parameter int NUM_READ  = 4,
  parameter int NUM_ALLOC = 2,
  parameter int NUM_WAKE  = 2,
  parameter int NUM_WALK  = 2,
  parameter int LAT_W     = LAT_W_DEFAULT
) (
  input logic               clock,
  input logic               reset_n,
  preg_ready_table_if.slave bus
);

  localparam int PREG_W = $clog2(PREG_SIZE);
  localparam int TBL    = 1 << PREG_W;

  logic             overwrite, walking;
  logic [TBL-1:0]   busyVec, bypassVec;
  logic [NUM_READ-1:0] busyOut;
  logic [PREG_W-1:0]   addr;
  logic                unusedLrd;

  assign overwrite = (bus.rob_state == ROB_STATE_OVERWRITE_RAT);
  assign walking   = (bus.rob_state == ROB_STATE_WALKING);
  assign unusedLrd = ^bus.walk_lrd;

  // Entry 0 is the hardwired always-ready register.
  assign busyVec[0]   = 1'b0;
  assign bypassVec[0] = 1'b0;

  for (genvar e = 1; e < PREG_SIZE; e++) begin : gEntry
    logic             allocHit, walkHit, wakeHit;
    logic [LAT_W-1:0] wakeLat;
    logic             wakeNow, wakeLoad, busy, expiring;

    // Wake ports are scanned high to low so the lowest index ends up winning.
    always_comb begin
      allocHit = 1'b0;
      walkHit  = 1'b0;
      wakeHit  = 1'b0;
      wakeLat  = '0;
      for (int i = 0; i < NUM_ALLOC; i++)
        if (bus.alloc_en[i] && bus.alloc_addr[i*PREG_W +: PREG_W] == PREG_W'(e))
          allocHit = !overwrite;
      for (int k = 0; k < NUM_WALK; k++)
        if (walking && bus.walk_valid[k] && bus.walk_prd[k*PREG_W +: PREG_W] == PREG_W'(e))
          walkHit = 1'b1;
      for (int j = NUM_WAKE - 1; j >= 0; j--)
        if (bus.wake_en[j] && bus.wake_addr[j*PREG_W +: PREG_W] == PREG_W'(e)) begin
          wakeHit = !overwrite;
          wakeLat = bus.wake_lat[j*LAT_W +: LAT_W];
        end
    end

    assign wakeNow  = wakeHit && (wakeLat == '0);
    assign wakeLoad = wakeHit && (wakeLat != '0);

    preg_ready_entry #(.LAT_W(LAT_W)) uEntry (
      .clock      (clock),
      .reset_n    (reset_n),
      .overwrite_i(overwrite),
      .walk_i     (walkHit),
      .wakeNow_i  (wakeNow),
      .alloc_i    (allocHit),
      .wakeLoad_i (wakeLoad),
      .wakeLat_i  (wakeLat),
      .busy_o     (busy),
      .expiring_o (expiring)
    );

    assign busyVec[e]   = busy;
    assign bypassVec[e] = wakeNow || expiring;
  end

  for (genvar e = PREG_SIZE; e < TBL; e++) begin : gPad
    assign busyVec[e]   = 1'b0;
    assign bypassVec[e] = 1'b0;
  end

`ifdef BUSYTABLE_BYPASS_EN
  always_comb begin
    busyOut = '0;
    addr    = '0;
    for (int r = 0; r < NUM_READ; r++) begin
      addr       = bus.read_addr[r*PREG_W +: PREG_W];
      busyOut[r] = busyVec[addr] && !bypassVec[addr];
    end
  end
`else
  logic unusedBypass;
  assign unusedBypass = ^bypassVec;

  always_comb begin
    busyOut = '0;
    addr    = '0;
    for (int r = 0; r < NUM_READ; r++) begin
      addr       = bus.read_addr[r*PREG_W +: PREG_W];
      busyOut[r] = busyVec[addr];
    end
  end
`endif

  assign bus.busy_out = busyOut;

endmodule
